// File: rtl/signal_pkg.sv
// Shared definitions for the highway/country signal controller and the
// country-road vehicle detector: light codes and detector FSM encoding.
package signal_pkg;

  typedef logic [1:0] light_t;
  typedef logic [1:0] state_t;

  // Light codes driven by the signal controller.
  localparam light_t LIGHT_RED    = 2'b00;
  localparam light_t LIGHT_YELLOW = 2'b01;
  localparam light_t LIGHT_GREEN  = 2'b10;
  localparam light_t LIGHT_UNUSED = 2'b11;

  // Vehicle detector request FSM.
  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_REQ     = 2'b01;
  localparam state_t ST_SERVE   = 2'b10;
  localparam state_t ST_RELEASE = 2'b11;

  // The unused code is treated as red so a confused controller fails safe.
  function automatic logic light_is_red(input light_t code);
    return (code == LIGHT_RED) || (code == LIGHT_UNUSED);
  endfunction

  function automatic logic light_is_green(input light_t code);
    return code == LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Loop-sensor front end: two-flop synchronizer followed by a debouncer.
// The debounced level det only flips after the synchronized level has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic loop_raw,
  output logic det
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          det_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous loop level.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= loop_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive disagreements, any agreement restarts the count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt   <= '0;
      det_q <= 1'b0;
    end else if (sync2 != det_q) begin
      if (cnt == CNT_LAST) begin
        det_q <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign det = det_q;

endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector. Turns the debounced loop level into a
// queued-car count and a car-waiting request x for the signal controller,
// watching the country light to know when the queue is being served. A
// service timeout caps how long x is held once country green is seen.
module vehicle_detector
  import signal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned MAX_SERVE_CYCLES = 16,
  parameter int unsigned CNT_W            = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       hwy,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             timeout
);

  localparam int unsigned SW = $clog2(MAX_SERVE_CYCLES + 1);
  // SERVE is entered with the counter at 0; exit happens on the edge where
  // it would reach MAX_SERVE_CYCLES-1, so x is held MAX_SERVE_CYCLES cycles
  // counting the REQ cycle that first saw green.
  localparam int unsigned SERVE_EXIT_INT = (MAX_SERVE_CYCLES >= 2) ? MAX_SERVE_CYCLES - 2 : 0;
  localparam logic [SW-1:0] SERVE_EXIT = SW'(SERVE_EXIT_INT);
  localparam logic [CNT_W-1:0] QUEUE_MAX = {CNT_W{1'b1}};

  logic             det;
  logic             det_q;
  logic             arrive;
  logic             depart;
  logic [CNT_W-1:0] queue_d;
  state_t           state_q;
  state_t           state_d;
  logic [SW-1:0]    serve_cnt_q;
  logic [SW-1:0]    serve_cnt_d;
  logic             x_d;
  logic             timeout_d;
  logic             unused_hwy;

  // The highway code is informational only.
  assign unused_hwy = ^hwy;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .clear   (clear),
    .loop_raw(loop_raw),
    .det     (det)
  );

  // Previous debounced level for edge detection.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      det_q <= 1'b0;
    end else begin
      det_q <= det;
    end
  end

  assign arrive = det & ~det_q;
  // A car leaving while country is not green is treated as creep, not service.
  assign depart = ~det & det_q & light_is_green(cntry);

  // Saturating queued-car count.
  always_comb begin
    queue_d = queue_cnt;
    if (arrive && (queue_cnt != QUEUE_MAX)) begin
      queue_d = queue_cnt + CNT_W'(1);
    end else if (depart && (queue_cnt != '0)) begin
      queue_d = queue_cnt - CNT_W'(1);
    end
  end

  // Request FSM next state, serve counter and timeout decision.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arrive || (queue_cnt != '0)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (light_is_green(cntry)) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        if (depart && (queue_d == '0)) begin
          // Queue drained; takes precedence over a coincident timeout.
          state_d = ST_RELEASE;
        end else if (serve_cnt_q >= SERVE_EXIT) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end else begin
          serve_cnt_d = serve_cnt_q + SW'(1);
        end
      end
      ST_RELEASE: begin
        if (light_is_red(cntry)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    x_d = (state_d == ST_REQ) || (state_d == ST_SERVE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      serve_cnt_q <= '0;
      queue_cnt   <= '0;
      x           <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      queue_cnt   <= queue_d;
      x           <= x_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector with default parameters.
module tb_vehicle_detector;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       x;
  logic [2:0] queue_cnt;
  logic       timeout;

  int n_cmp;
  int n_err;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;

  vehicle_detector #(
    .DEBOUNCE_CYCLES (4),
    .MAX_SERVE_CYCLES(16),
    .CNT_W           (3)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .loop_raw (loop_raw),
    .hwy      (hwy),
    .cntry    (cntry),
    .x        (x),
    .queue_cnt(queue_cnt),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    loop_raw = 1'b0;
    cntry    = RED;
    step(2);
    clear = 1'b0;
  endtask

  // One car: loop high for hi sampled edges, then low for lo edges.
  task automatic car(input int hi, input int lo);
    loop_raw = 1'b1;
    step(hi);
    loop_raw = 1'b0;
    step(lo);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clear    = 1'b1;
    loop_raw = 1'b0;
    hwy      = GREEN;
    cntry    = RED;
    step(2);
    check("rst_x", x, 0);
    check("rst_q", queue_cnt, 0);
    check("rst_to", timeout, 0);
    clear = 1'b0;

    // Glitch: 3 high samples never pass the debouncer.
    loop_raw = 1'b1;
    step(3);
    loop_raw = 1'b0;
    step(10);
    check("glitch_x", x, 0);
    check("glitch_q", queue_cnt, 0);

    // 5 high samples: det rises edge 6, x and count at edge 7.
    loop_raw = 1'b1;
    step(5);
    loop_raw = 1'b0;
    step(1);
    check("lat_e6_x", x, 0);
    step(1);
    check("lat_e7_x", x, 1);
    check("lat_e7_q", queue_cnt, 1);
    // Falling edge while red is ignored.
    step(8);
    check("creep_q", queue_cnt, 1);
    check("creep_x", x, 1);

    // Single car served.
    do_clear();
    loop_raw = 1'b1;
    step(7);
    check("car_e7_x", x, 1);
    step(3);
    cntry = YELLOW;
    step(7);
    check("car_yel_x", x, 1);
    cntry = GREEN;
    step(1);
    loop_raw = 1'b0;
    step(6);
    check("car_e24_x", x, 1);
    check("car_e24_q", queue_cnt, 1);
    step(1);
    check("car_dep_x", x, 0);
    check("car_dep_q", queue_cnt, 0);
    check("car_dep_to", timeout, 0);
    cntry = YELLOW;
    step(2);
    check("car_rel_x", x, 0);
    cntry = RED;
    step(3);
    check("car_idle_x", x, 0);
    check("car_idle_q", queue_cnt, 0);

    // Timeout with two queued cars, then recovery through the 2'b11 code.
    do_clear();
    car(5, 7);
    car(5, 7);
    check("to_q2", queue_cnt, 2);
    check("to_req_x", x, 1);
    cntry = GREEN;
    step(15);
    check("to_e15_x", x, 1);
    check("to_e15_to", timeout, 0);
    step(1);
    check("to_e16_x", x, 0);
    check("to_e16_to", timeout, 1);
    check("to_e16_q", queue_cnt, 2);
    step(1);
    check("to_e17_to", timeout, 0);
    check("to_e17_x", x, 0);
    cntry = BAD;
    step(1);
    check("bad_idle_x", x, 0);
    step(1);
    check("bad_rereq_x", x, 1);
    check("bad_rereq_q", queue_cnt, 2);

    // Saturation with red light.
    do_clear();
    car(5, 7);
    check("sat_q1", queue_cnt, 1);
    for (int i = 0; i < 8; i++) car(5, 7);
    check("sat_q7", queue_cnt, 7);
    step(10);
    check("sat_hold_q", queue_cnt, 7);

    // Asynchronous clear mid-cycle.
    do_clear();
    for (int i = 0; i < 3; i++) car(5, 7);
    check("arst_pre_q", queue_cnt, 3);
    check("arst_pre_x", x, 1);
    #2;
    clear = 1'b1;
    #1;
    check("arst_x", x, 0);
    check("arst_q", queue_cnt, 0);
    step(1);
    clear = 1'b0;
    step(10);
    check("arst_after_x", x, 0);
    check("arst_after_q", queue_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vehicle_detector.md
# vehicle_detector

Country-road vehicle detector that produces the car-waiting request `x` consumed by the highway/country signal controller, and observes that controller's `hwy`/`cntry` light codes to know when the request has been served. It synchronizes and debounces a raw inductive-loop level, keeps a saturating count of queued country-road cars, and shapes `x` with a maximum-service timeout so the highway is never starved. It sits between the loop-sensor pad and the signal controller, on the same clock.

## Interface

- `DEBOUNCE_CYCLES`, 4, consecutive synchronized cycles a new loop level must hold before it is accepted (≥1)
- `MAX_SERVE_CYCLES`, 16, max cycles `x` is held once country green is seen (≥1)
- `CNT_W`, 3, width of queued-car counter
- `clk` input 1 — rising-edge clock
- `clear` input 1 — reset, asynchronous, active-high
- `loop_raw` input 1 — raw asynchronous loop level, 1 = vehicle over loop
- `hwy` input 2 — highway light code from controller (informational, unused for decisions)
- `cntry` input 2 — country light code from controller
- `x` output 1 — registered car-waiting request to controller
- `queue_cnt` output CNT_W — registered queued-car count
- `timeout` output 1 — registered one-cycle pulse when service is cut by `MAX_SERVE_CYCLES`

One clock; reset is asynchronous and active-high.

## Operation

- Light codes: red=2'b00, yellow=2'b01, green=2'b10; code 2'b11 on `cntry` is treated as red.
- Front end: 2-flop synchronizer on `loop_raw` → debouncer; debounced level `det` changes only after the synchronized level differs from `det` for `DEBOUNCE_CYCLES` consecutive cycles; any mismatch break restarts the count.
- `arrive` = `det` rising edge; `depart` = `det` falling edge while `cntry`==green. Falling edges on non-green are ignored (queue creep).
- `queue_cnt`: +1 on `arrive`, saturating at 2^CNT_W−1; −1 on `depart`, floor 0. `arrive` and `depart` cannot coincide.
- FSM, states IDLE, REQ, SERVE, RELEASE; `x`=1 in REQ and SERVE only:
  - IDLE: → REQ when `arrive` or `queue_cnt`>0.
  - REQ: → SERVE when `cntry`==green.
  - SERVE: serve counter increments each cycle from 0; → RELEASE when `queue_cnt` reaches 0 (after a `depart`), or when counter reaches `MAX_SERVE_CYCLES`−1 (assert `timeout` for one cycle). If both on the same cycle, go to RELEASE without `timeout`.
  - RELEASE: `x`=0; → IDLE when `cntry`==red. Count is retained, so leftover cars re-request via IDLE→REQ next cycle.
- `hwy` is not used for decisions.

## Timing

- Reset values: `x`=0, `queue_cnt`=0, `timeout`=0, FSM=IDLE, synchronizer/debouncer/serve counters 0, `det`=0.
- Loop-to-request latency: first edge sampling `loop_raw`=1 is edge 1; `det` rises at edge `DEBOUNCE_CYCLES`+2; `queue_cnt` increments and `x` rises at edge `DEBOUNCE_CYCLES`+3 (edge 7 at default).
- `x` falls on the edge that enters RELEASE; `timeout` is high for exactly the cycle after that edge.
- Controller handshake: `x` stays 1 until SERVE exits, independent of `cntry` yellow/red transitions before green.
- `clear` mid-operation: all state returns to reset values immediately, without waiting for a clock edge; queued cars are lost.

## Structure

- Shared package `signal_pkg`: light-code constants (red/yellow/green) and FSM state encoding, also used by the signal controller.
- One sub-module `sync_debounce`: synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`, output `det`.
- Top holds edge detect, queue counter, FSM and serve counter.

## Test plan

- Reset: assert `clear` asynchronously mid-cycle with `queue_cnt`=3 and `x`=1 → `x`=0 and `queue_cnt`=0 immediately; `x` stays 0 after release until a new arrival.
- Glitch rejection: `loop_raw` high for 3 cycles (`DEBOUNCE_CYCLES`=4) → no `arrive`, `x` stays 0; 5-cycle high → `x`=1 at edge 7.
- Single car: arrive, controller drives `cntry` red→green after 10 cycles, car leaves at cycle 3 of green → `queue_cnt` 1→0, `x` falls same edge, FSM reaches IDLE once `cntry`=red.
- Timeout: 2 cars queued, `cntry` green, no departures → `timeout` pulse and `x`=0 after 16 green cycles; `cntry`→red → `x` returns to 1 the cycle after IDLE is reached (`queue_cnt`=2).
- Saturation/floor: 9 arrivals with `cntry` red (CNT_W=3) → `queue_cnt`=7; falling edges while red → `queue_cnt` unchanged.
- Invalid code: `cntry`=2'b11 while in RELEASE → treated as red, FSM → IDLE.
